sample_buffer: RTL and testbench
================================

SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 capture_start  input  1  single-cycle pulse; arms a new 128-word capture.
REQ-005 wr_valid  input  1  sample-write strobe from the receive front end.
REQ-006 wr_data  input  25  sample word, written when accepted.
REQ-007 rd_en  input  1  random-read request from the ControlUnit.
REQ-008 read_add  input  7  random-read address.
REQ-009 read_data  output  25  random-read result.
REQ-010 send_enB  output  1  stream-valid strobe to the ControlUnit.
REQ-011 buf_out  output  25  stream word to the ControlUnit buf_in; valid while send_enB=1.
REQ-012 full  output  1  high from the 128th accepted write until the stream completes.
REQ-013 count  output  8  number of words written in the current capture (0..128).
REQ-014 dropped  output  1  sticky flag: wr_valid arrived while not in CAPTURE.

Function
REQ-015 FSM states: IDLE, CAPTURE, STREAM; reset state is IDLE.
REQ-016 IDLE->CAPTURE on capture_start=1; count and wr_ptr clear to 0; dropped clears in the same cycle.
REQ-017 CAPTURE: each wr_valid=1 cycle writes wr_data to mem[wr_ptr]; wr_ptr and count each increment by 1.
REQ-018 CAPTURE->STREAM on the cycle the 128th write is accepted; full rises on the next edge; wr_ptr wraps to 0 (7-bit).
REQ-019 capture_start during CAPTURE restarts the capture (count=0, wr_ptr=0); no write occurs that cycle even if wr_valid=1.
REQ-020 capture_start during STREAM is ignored.
REQ-021 wr_valid in IDLE or STREAM writes nothing and sets dropped=1.
REQ-022 STREAM: the block reads mem[0..127] in order, one word per cycle; send_enB=1 for exactly 128 consecutive cycles, with buf_out=mem[k] on the k-th strobe.
REQ-023 The first send_enB cycle is 2 cycles after the edge that accepted the 128th write, due to 1-cycle RAM read latency plus an output register.
REQ-024 After the 128th strobe: send_enB=0, full=0, count=0, state returns to IDLE.
REQ-025 Random read: rd_en=1 at edge N gives read_data=mem[read_add] after edge N+1; with rd_en=0, read_data holds its value.
REQ-026 Random reads are legal in every state and do not disturb streaming; the RAM read ports are independent.
REQ-027 Read and write to the same address in the same cycle return the old data (read-first).
REQ-028 buf_out holds its last value when send_enB=0.

Reset
REQ-029 rst_n=0: state=IDLE; read_data, buf_out, count=0; send_enB, full, dropped=0; all pointers=0.
REQ-030 Reset need not clear RAM contents; reset mid-STREAM drops send_enB in the same cycle (asynchronous).

Structure
REQ-031 Package ultrasonic_pkg holds DATA_W=25, DEPTH=128, ADDR_W=7 and the enum buf_state_t {IDLE, CAPTURE, STREAM}.
REQ-032 Storage is one sub-module, sample_ram: 128x25 synchronous RAM with one write port and two read ports, read-first, no reset.
REQ-033 The FSM, pointers and output registers are implemented in sample_buffer.

Verification
REQ-034 Reset then capture_start, followed by 128 writes of data=index -> full=1; send_enB high for 128 cycles starting 2 cycles after the last write; buf_out sequence 0..127; then IDLE with count=0.
REQ-035 wr_valid=1 with wr_data=25'h1ABCDEF while in IDLE -> dropped=1, count=0; the next capture_start clears dropped.
REQ-036 capture_start after 50 writes, then 128 writes of 25'h0000100+i -> stream outputs 25'h0000100..25'h000017F.
REQ-037 rd_en=1, read_add=7'd5 during STREAM -> read_data=mem[5] one cycle later; the stream sequence is unbroken.
REQ-038 rst_n pulsed low at stream word 60 -> send_enB=0 immediately; all outputs 0; the next capture_start works normally.
REQ-039 Read and write to address 3 in the same cycle (old 25'h1, new 25'h2) -> read_data=25'h1.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared sizing and state type for the ultrasonic sample capture path.
package ultrasonic_pkg;
    localparam int unsigned DATA_W = 25;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        STREAM
    } buf_state_t;
endpackage

// File: rtl/sample_buffer_if.sv
// Capture/stream/random-read signal bundle between front end, ControlUnit and sample_buffer.
interface sample_buffer_if;
    import ultrasonic_pkg::*;

    logic                capture_start;
    logic                wr_valid;
    logic [DATA_W-1:0]   wr_data;
    logic                rd_en;
    logic [ADDR_W-1:0]   read_add;
    logic [DATA_W-1:0]   read_data;
    logic                send_enB;
    logic [DATA_W-1:0]   buf_out;
    logic                full;
    logic [CNT_W-1:0]    count;
    logic                dropped;

    modport slave (
        input  capture_start, wr_valid, wr_data, rd_en, read_add,
        output read_data, send_enB, buf_out, full, count, dropped
    );

    modport master (
        output capture_start, wr_valid, wr_data, rd_en, read_add,
        input  read_data, send_enB, buf_out, full, count, dropped
    );
endinterface

// File: rtl/sample_ram.sv
// 128x25 synchronous RAM: one write port, two independent registered read ports, read-first.
module sample_ram
    import ultrasonic_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_a_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic              re_b_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reads sample the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (we_i)   mem_q[waddr_i] <= wdata_i;
        if (re_a_i) rdata_a_o      <= mem_q[raddr_a_i];
        if (re_b_i) rdata_b_o      <= mem_q[raddr_b_i];
    end
endmodule

// File: rtl/sample_buffer.sv
// Captures 128 samples into sample_ram, then streams them out in order; random reads run alongside.
module sample_buffer
    import ultrasonic_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    sample_buffer_if.slave  bus
);
    buf_state_t          state_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                full_q;
    logic                dropped_q;
    logic                issue_done_q;
    logic                pend_q;
    logic                pend_last_q;
    logic                send_q;
    logic                send_last_q;
    logic                rd_pend_q;
    logic [DATA_W-1:0]   read_data_q;
    logic [DATA_W-1:0]   buf_out_q;

    logic                wr_accept;
    logic                issue;
    logic [DATA_W-1:0]   ram_rdata_a;
    logic [DATA_W-1:0]   ram_rdata_b;

    assign wr_accept = (state_q == CAPTURE) && bus.wr_valid && !bus.capture_start;
    assign issue     = (state_q == STREAM) && !issue_done_q;

    sample_ram u_ram (
        .clk       (clk),
        .we_i      (wr_accept),
        .waddr_i   (wr_ptr_q),
        .wdata_i   (bus.wr_data),
        .re_a_i    (bus.rd_en),
        .raddr_a_i (bus.read_add),
        .rdata_a_o (ram_rdata_a),
        .re_b_i    (issue),
        .raddr_b_i (rd_ptr_q),
        .rdata_b_o (ram_rdata_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            dropped_q    <= 1'b0;
            issue_done_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            send_q       <= 1'b0;
            send_last_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
            read_data_q  <= '0;
            buf_out_q    <= '0;
        end else begin
            rd_pend_q <= bus.rd_en;
            if (rd_pend_q) read_data_q <= ram_rdata_a;

            // Stream pipeline: address issue -> RAM register -> output register.
            pend_q      <= issue;
            pend_last_q <= issue && (rd_ptr_q == '1);
            send_q      <= pend_q;
            send_last_q <= pend_last_q;
            if (pend_q) buf_out_q <= ram_rdata_b;

            if (issue) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                if (rd_ptr_q == '1) issue_done_q <= 1'b1;
            end

            if (bus.wr_valid && (state_q != CAPTURE)) dropped_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.capture_start) begin
                        state_q   <= CAPTURE;
                        count_q   <= '0;
                        wr_ptr_q  <= '0;
                        dropped_q <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (bus.capture_start) begin
                        count_q  <= '0;
                        wr_ptr_q <= '0;
                    end else if (bus.wr_valid) begin
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                        count_q  <= count_q + CNT_W'(1);
                        if (count_q == CNT_W'(DEPTH - 1)) begin
                            state_q      <= STREAM;
                            full_q       <= 1'b1;
                            rd_ptr_q     <= '0;
                            issue_done_q <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    if (send_q && send_last_q) begin
                        state_q <= IDLE;
                        full_q  <= 1'b0;
                        count_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.send_enB  = send_q;
    assign bus.buf_out   = buf_out_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.dropped   = dropped_q;
endmodule

// File: tb/tb_sample_buffer.sv
// Directed + randomized bench for sample_buffer against an array/counter reference model.
module tb_sample_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sample_buffer_if bus ();

    sample_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [24:0] mmem [128];
    int          mcount = 0;
    int          mptr = 0;
    bit          mdropped = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_send"},  32'(bus.send_enB),  32'd0);
        chk({tag, "_full"},  32'(bus.full),      32'd0);
        chk({tag, "_count"}, 32'(bus.count),     32'd0);
        chk({tag, "_drop"},  32'(bus.dropped),   32'd0);
        chk({tag, "_rdat"},  32'(bus.read_data), 32'd0);
        chk({tag, "_bout"},  32'(bus.buf_out),   32'd0);
    endtask

    task automatic start_capture(input bit from_idle);
        bus.capture_start = 1'b1;
        step();
        bus.capture_start = 1'b0;
        mcount = 0;
        mptr   = 0;
        if (from_idle) mdropped = 1'b0;
    endtask

    task automatic write_word(input logic [24:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        step();
        bus.wr_valid = 1'b0;
        mmem[mptr] = d;
        mptr   = (mptr + 1) % 128;
        mcount = mcount + 1;
        chk("wr_count", 32'(bus.count), 32'(mcount));
    endtask

    // Entered one sample point after the edge that took the 128th write.
    task automatic stream_check(input int stop_at);
        chk("full_rise", 32'(bus.full), 32'd1);
        chk("lat0", 32'(bus.send_enB), 32'd0);
        step();
        chk("lat1", 32'(bus.send_enB), 32'd0);
        step();
        for (int k = 0; k < stop_at; k++) begin
            chk("stream_en",  32'(bus.send_enB), 32'd1);
            chk("stream_dat", 32'(bus.buf_out),  32'(mmem[k]));
            if (k == 20) begin bus.rd_en = 1'b1; bus.read_add = 7'd5; end
            if (k == 21) bus.rd_en = 1'b0;
            if (k == 22) chk("rd_in_stream", 32'(bus.read_data), 32'(mmem[5]));
            if (k == 30) bus.capture_start = 1'b1;
            if (k == 31) bus.capture_start = 1'b0;
            if (k == 40) begin bus.wr_valid = 1'b1; bus.wr_data = 25'($urandom); mdropped = 1'b1; end
            if (k == 41) bus.wr_valid = 1'b0;
            if (k == stop_at - 1 && stop_at < 128) break;
            step();
        end
        if (stop_at == 128) begin
            chk("end_send",  32'(bus.send_enB), 32'd0);
            chk("end_full",  32'(bus.full),     32'd0);
            chk("end_count", 32'(bus.count),    32'd0);
            chk("end_drop",  32'(bus.dropped),  32'(mdropped));
            mcount = 0;
        end
    endtask

    initial begin
        logic [24:0] old3;
        logic [24:0] exp_rd;
        int          addr;

        bus.capture_start = 1'b0;
        bus.wr_valid      = 1'b0;
        bus.wr_data       = '0;
        bus.rd_en         = 1'b0;
        bus.read_add      = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Write while idle is dropped; next capture_start clears it.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 25'h1ABCDEF;
        step();
        bus.wr_valid = 1'b0;
        mdropped = 1'b1;
        chk("idle_drop",  32'(bus.dropped), 32'd1);
        chk("idle_count", 32'(bus.count),   32'd0);
        start_capture(1'b1);
        chk("start_drop_clr", 32'(bus.dropped), 32'd0);
        chk("start_count",    32'(bus.count),   32'd0);

        // Index pattern capture and full stream.
        for (int i = 0; i < 128; i++) write_word(25'(i));
        chk("count_128", 32'(bus.count), 32'd128);
        stream_check(128);

        // Restart after 50 writes; the restart cycle's write must be discarded.
        start_capture(1'b1);
        for (int i = 0; i < 50; i++) write_word(25'($urandom));
        bus.capture_start = 1'b1;
        bus.wr_valid      = 1'b1;
        bus.wr_data       = 25'($urandom);
        step();
        bus.capture_start = 1'b0;
        bus.wr_valid      = 1'b0;
        mcount = 0;
        mptr   = 0;
        chk("restart_count", 32'(bus.count), 32'd0);
        for (int i = 0; i < 128; i++) write_word(25'h0000100 + 25'(i));
        stream_check(128);

        // Same-cycle read and write of address 3 returns the old word.
        start_capture(1'b1);
        for (int i = 0; i < 3; i++) write_word(25'($urandom));
        write_word(25'h1);
        start_capture(1'b0);
        for (int i = 0; i < 3; i++) write_word(25'($urandom));
        old3 = mmem[3];
        bus.rd_en    = 1'b1;
        bus.read_add = 7'd3;
        write_word(25'h2);
        bus.rd_en = 1'b0;
        step();
        chk("read_first", 32'(bus.read_data), 32'(old3));

        // Finish the capture with random data; reset asynchronously at stream word 60.
        for (int i = 4; i < 128; i++) write_word(25'($urandom));
        stream_check(61);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        mdropped = 1'b0;
        mcount   = 0;
        step();

        // Capture after reset behaves normally.
        start_capture(1'b1);
        for (int i = 0; i < 128; i++) write_word(25'($urandom));
        stream_check(128);

        // Random reads while idle, plus hold when rd_en is low.
        for (int n = 0; n < 6; n++) begin
            addr = int'($urandom_range(0, 127));
            exp_rd = mmem[addr];
            bus.rd_en    = 1'b1;
            bus.read_add = 7'(addr);
            step();
            bus.rd_en    = 1'b0;
            bus.read_add = 7'($urandom);
            step();
            chk("idle_rd", 32'(bus.read_data), 32'(exp_rd));
            step();
            chk("idle_rd_hold", 32'(bus.read_data), 32'(exp_rd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
